mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_W, 10, byte address width; DATA_W, 8, data width; STARVE_MAX, 3, max consecutive fetch denials under contention.
REQ-002 SHALL have ports: clk  in  1  clock, all state on posedge.
REQ-003 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-004 SHALL have fetch (read-only) ports: f_req in 1; f_addr in ADDR_W; f_gnt out 1; f_rvalid out 1; f_rdata out DATA_W.
REQ-005 SHALL have data ports: d_req in 1; d_we in 1; d_lock in 1 (hold grant for atomic RMW); d_addr in ADDR_W; d_wdata in DATA_W; d_gnt out 1; d_rvalid out 1; d_rdata out DATA_W.
REQ-006 SHALL have memory-side ports: m_addr out ADDR_W; m_wen out 1; m_wdata out DATA_W; m_rdata in DATA_W (1-cycle registered read, read-during-write returns old data).

Function
REQ-007 SHALL grant combinationally in the request cycle; at most one of f_gnt/d_gnt high per cycle; gnt never high without matching req.
REQ-008 SHALL drive m_addr/m_wen/m_wdata from the granted port; m_wen = d_gnt & d_we; with no grant m_wen=0, m_addr=f_addr, m_wdata=0.
REQ-009 SHALL assert f_rvalid one cycle after f_gnt, and d_rvalid one cycle after d_gnt with d_we=0; writes never produce d_rvalid.
REQ-010 SHALL drive f_rdata and d_rdata = m_rdata; values meaningful only while respective rvalid is high.
REQ-011 SHALL, with a single requester, grant it every cycle (full throughput, back-to-back).
REQ-012 SHALL implement FSM states IDLE and LOCK: IDLE->LOCK on d_gnt with d_lock=1; LOCK->IDLE on cycle with d_req=0, or d_gnt with d_lock=0.
REQ-013 SHALL in LOCK deny fetch unconditionally and grant data whenever d_req=1; starvation counting frozen in LOCK.
REQ-014 SHALL resolve contention (both req, state IDLE) per the Configuration policy.
REQ-015 SHALL keep a denial counter: increments on cycles with f_req=1 and f_gnt=0 in IDLE, saturates at STARVE_MAX, clears on f_gnt or f_req=0.
REQ-016 SHALL not buffer requests; a denied requester holds req/addr/data stable until granted.

Reset
REQ-017 SHALL on rst: f_rvalid=0, d_rvalid=0, state IDLE, denial counter 0, last-grant register = data; grants during rst cycle forced 0, m_wen=0.
REQ-018 SHALL drop any read in flight at reset (no rvalid the cycle after reset deasserts).

Configuration
REQ-019 SHALL, with MEM_ARB_RR_EN defined, resolve contention round-robin: grant the port not granted most recently (fetch first after reset); denial counter unused.
REQ-020 SHALL, without MEM_ARB_RR_EN, give data priority, except grant fetch when denial counter == STARVE_MAX.

Structure
REQ-021 SHALL place ADDR_W/DATA_W defaults, STARVE_MAX default and the FSM state enum (ARB_IDLE, ARB_LOCK) in package mem_arb_pkg.
REQ-022 SHALL be a single module with no sub-module; the memory is instantiated alongside it by the parent.

Verification
REQ-023 Bench SHALL cover: fetch-only reads addr 0..3 back-to-back -> f_gnt every cycle, f_rvalid cycles 1..4 with preloaded bytes 0x20,0x09,0x0a,0x20.
REQ-024 Bench SHALL cover: data write 0x5A to addr 0x3FF, then read 0x3FF -> no d_rvalid on write, d_rvalid next cycle after read with d_rdata=0x5A.
REQ-025 Bench SHALL cover (priority build): both req continuously -> d_gnt 3 cycles, f_gnt on 4th, pattern repeats; RR build -> strict alternation starting with fetch.
REQ-026 Bench SHALL cover: d_lock=1 read addr 5 then d_lock=0 write addr 5 with f_req held -> f_gnt=0 both cycles, fetch granted on third cycle.
REQ-027 Bench SHALL cover: rst asserted the cycle after a fetch grant -> f_rvalid stays 0, state IDLE, first post-reset contention follows reset policy.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared defaults and state encoding for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int DATA_W_DEF     = 8;
    localparam int STARVE_MAX_DEF = 3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory with 1-cycle reads.
// MEM_ARB_RR_EN selects round-robin contention; default is data priority with fetch anti-starvation.
//
// state    | meaning
// ARB_IDLE | normal arbitration, contention resolved by policy
// ARB_LOCK | data port holds the memory for an atomic RMW, fetch denied
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wen,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_e state_q, state_d;
    logic       f_rvalid_q, d_rvalid_q;

`ifdef MEM_ARB_RR_EN
    logic last_d_q, last_d_d;
`else
    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] deny_cnt_q, deny_cnt_d;
`endif

    always_comb begin
        f_gnt   = 1'b0;
        d_gnt   = 1'b0;
        state_d = state_q;

        if (!rst) begin
            if (state_q == ARB_LOCK) begin
                d_gnt = d_req;
            end else if (f_req && d_req) begin
`ifdef MEM_ARB_RR_EN
                f_gnt = last_d_q;
`else
                f_gnt = (deny_cnt_q == CNT_W'(STARVE_MAX));
`endif
                d_gnt = !f_gnt;
            end else begin
                f_gnt = f_req;
                d_gnt = d_req;
            end
        end

        case (state_q)
            ARB_IDLE: if (d_gnt && d_lock) state_d = ARB_LOCK;
            ARB_LOCK: if (!d_req || (d_gnt && !d_lock)) state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase

`ifdef MEM_ARB_RR_EN
        last_d_d = last_d_q;
        if (d_gnt) begin
            last_d_d = 1'b1;
        end else if (f_gnt) begin
            last_d_d = 1'b0;
        end
`else
        // Denial history is frozen while a locked sequence owns the memory.
        deny_cnt_d = deny_cnt_q;
        if (state_q == ARB_IDLE) begin
            if (f_gnt || !f_req) begin
                deny_cnt_d = '0;
            end else if (deny_cnt_q != CNT_W'(STARVE_MAX)) begin
                deny_cnt_d = deny_cnt_q + CNT_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_d_q   <= 1'b1;
`else
            deny_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            f_rvalid_q <= f_gnt;
            d_rvalid_q <= d_gnt && !d_we;
`ifdef MEM_ARB_RR_EN
            last_d_q   <= last_d_d;
`else
            deny_cnt_q <= deny_cnt_d;
`endif
        end
    end

    assign m_addr  = d_gnt ? d_addr : f_addr;
    assign m_wen   = d_gnt && d_we;
    assign m_wdata = d_gnt ? d_wdata : '0;

    // Reads completing into a reset cycle are discarded rather than reported.
    assign f_rvalid = f_rvalid_q && !rst;
    assign d_rvalid = d_rvalid_q && !rst;
    assign f_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

endmodule
